// File: rtl/user_press.sv
// user_press: debounced push-button press detector with pulse output, debounced level and press counter.
// Optional auto-repeat on a long hold is compiled in when USER_PRESS_AUTO_REPEAT_EN is defined.
module user_press #(
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out,
  output logic       held,
  output logic [7:0] presses
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("user_press: DEBOUNCE must be 1..255");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_delay
    $error("user_press: REPEAT_DELAY must be 1..255");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_period
    $error("user_press: REPEAT_PERIOD must be 1..REPEAT_DELAY");
  end

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       out_d, held_d;

`ifdef USER_PRESS_AUTO_REPEAT_EN
  localparam logic [7:0] RPT_LAST   = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [7:0] rpt, rpt_d;
  logic       fire;
`endif

  // State, debounce counter and registered outputs; reset discards any press in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      out     <= 1'b0;
      held    <= 1'b0;
      presses <= '0;
`ifdef USER_PRESS_AUTO_REPEAT_EN
      rpt     <= '0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      out     <= out_d;
      held    <= held_d;
      presses <= presses + 8'(out_d);
`ifdef USER_PRESS_AUTO_REPEAT_EN
      rpt     <= rpt_d;
`endif
    end
  end

  // Next-state: count consecutive samples that disagree with the debounced level before accepting a change.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    out_d   = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_d = PRESS_WAIT;
          cnt_d   = 8'd1;
        end
      end
      PRESS_WAIT: begin
        if (!in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DB) begin
          state_d = HELD;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!in) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 8'd1;
        end
      end
      RELEASE_WAIT: begin
        if (in) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == DB) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef USER_PRESS_AUTO_REPEAT_EN
    fire  = state == HELD && in && rpt == RPT_LAST;
    rpt_d = (state == HELD && in) ? (fire ? RPT_RELOAD : rpt + 8'd1) : '0;
    out_d = out_d | fire;
`endif
    held_d = state_d == HELD || state_d == RELEASE_WAIT;
  end

endmodule

// File: tb/tb_user_press.sv
// tb_user_press: randomized and directed check of user_press against a sample-counting reference model.
module tb_user_press;
  localparam int DB = 4, RD = 16, RP = 4;

  logic       clk = 1'b0, reset = 1'b0, in = 1'b0;
  logic       out, held;
  logic [7:0] presses;
  int         errors = 0, checks = 0;

  bit         m_pressed, m_out;
  int         m_run, m_age;
  logic [7:0] m_presses;
  logic [7:0] p0;

  user_press #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .held(held), .presses(presses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, 8'(out), 8'(m_out));
    chk({tag, ".held"}, 8'(held), 8'(m_pressed));
    chk({tag, ".presses"}, presses, m_presses);
  endtask

  task automatic model_reset();
    m_pressed = 0;
    m_out     = 0;
    m_run     = 0;
    m_age     = 0;
    m_presses = '0;
  endtask

  // Level accepted after DEBOUNCE+1 consecutive disagreeing samples; age counts stable held-high cycles.
  task automatic model_step(input bit b);
    m_out = 0;
    if (!m_pressed) begin
      if (b) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_pressed = 1;
          m_run     = 0;
          m_age     = 0;
          m_out     = 1;
        end
      end else m_run = 0;
    end else if (m_run == 0 && b) begin
      m_age++;
`ifdef USER_PRESS_AUTO_REPEAT_EN
      if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) m_out = 1;
`endif
    end else begin
      m_age = 0;
      if (b) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB + 1) begin
          m_pressed = 0;
          m_run     = 0;
        end
      end
    end
    if (m_out) m_presses++;
  endtask

  task automatic step(input bit b, input string tag);
    in = b;
    @(posedge clk);
    model_step(b);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    bit seq[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("reset_pre_clk");
    @(posedge clk);
    #1 check_all("reset_clk");
    reset = 1'b0;

    repeat (4) step(1, "short_press");
    repeat (6) step(0, "short_release");
    chk("short_presses", presses, 8'd0);

    repeat (12) step(1, "hold12");
    chk("hold12_presses", presses, 8'd1);
    chk("hold12_held", 8'(held), 8'd1);

    foreach (seq[i]) step(seq[i], "release_bounce");
    chk("bounce_held", 8'(held), 8'd0);
    chk("bounce_presses", presses, 8'd1);

    async_reset("reset_idle");
    for (int i = 0; i < 256; i++) begin
      repeat (DB + 1) step(1, "wrap_press");
      repeat (DB + 1) step(0, "wrap_release");
    end
    chk("wrap_presses", presses, 8'd0);

    repeat (DB + 4) step(1, "mid_held");
    async_reset("reset_mid_held");
    repeat (DB + 3) step(1, "after_reset_hold");
    repeat (DB + 2) step(0, "after_reset_release");

    repeat (DB + 1) step(1, "repeat_entry");
    p0 = presses;
    repeat (30) step(1, "repeat_hold");
`ifdef USER_PRESS_AUTO_REPEAT_EN
    chk("repeat_extra_pulses", presses - p0, 8'd4);
`else
    chk("repeat_extra_pulses", presses - p0, 8'd0);
`endif
    repeat (DB + 2) step(0, "repeat_release");

    for (int r = 0; r < 1500; r++) begin
      bit b;
      int len;
      b   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(RD, RD + 3 * RP)) : int'($urandom_range(1, 2 * DB + 3));
      repeat (len) step(b, "random");
      if ($urandom_range(0, 99) == 0) async_reset("random_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
